// File: rtl/eth_tx_arb.sv
// Packet-granular fixed-priority arbiter for the MAC TX stream, with a starvation guard for the last source.
// Optional source-stall watchdog (TERM/DRAIN recovery) is enabled by defining ETH_TX_ARB_WDOG_EN.
module eth_tx_arb #(
  parameter int DW           = 32,
  parameter int NREQ         = 3,
  parameter int STARVE_LIMIT = 4,
  parameter int WDOG_CYCLES  = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*DW-1:0] i_data,
  input  logic [NREQ-1:0]    i_vld,
  input  logic [NREQ-1:0]    i_sop,
  input  logic [NREQ-1:0]    i_eop,
  output logic [NREQ-1:0]    o_rdy,
  output logic [NREQ-1:0]    o_gnt,
  output logic [DW-1:0]      o_data,
  output logic               o_vld,
  output logic               o_sop,
  output logic               o_eop,
  input  logic               i_rdy,
  output logic               o_busy,
  output logic [31:0]        o_pkt_cnt,
  output logic               o_abort
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

`ifdef ETH_TX_ARB_WDOG_EN
  typedef enum logic [1:0] {IDLE, XFER, TERM, DRAIN} state_t;
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
  logic [WW-1:0] wdog_q, wdog_d;
`else
  typedef enum logic {IDLE, XFER} state_t;
`endif

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] win;
  logic            found;
  logic [SW-1:0]   starve_q, starve_d;
  logic [31:0]     pkt_cnt_q;
  logic            pkt_done;
  logic [DW-1:0]   sel_data;
  logic            sel_vld, sel_sop, sel_eop;

  // Grant is one-hot, so the source mux is a simple priority-free select.
  always_comb begin
    sel_data = '0;
    sel_vld  = 1'b0;
    sel_sop  = 1'b0;
    sel_eop  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_q[k]) begin
        sel_data = i_data[k*DW +: DW];
        sel_vld  = i_vld[k];
        sel_sop  = i_sop[k];
        sel_eop  = i_eop[k];
      end
    end
  end

  // Lowest index wins unless the last source has waited through STARVE_LIMIT grants.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (i_req[k] && !found) begin
        win[k] = 1'b1;
        found  = 1'b1;
      end
    end
    if (i_req[NREQ-1] && (starve_q == STARVE_MAX)) begin
      win         = '0;
      win[NREQ-1] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    starve_d = starve_q;
    pkt_done = 1'b0;
    o_data   = '0;
    o_vld    = 1'b0;
    o_sop    = 1'b0;
    o_eop    = 1'b0;
    o_rdy    = '0;
    o_abort  = 1'b0;
`ifdef ETH_TX_ARB_WDOG_EN
    wdog_d   = wdog_q;
`endif
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          gnt_d   = win;
          state_d = XFER;
`ifdef ETH_TX_ARB_WDOG_EN
          wdog_d  = '0;
`endif
          if (win[NREQ-1])
            starve_d = '0;
          else if (i_req[NREQ-1] && (starve_q != STARVE_MAX))
            starve_d = starve_q + 1'b1;
        end
      end
      XFER: begin
        o_data = sel_data;
        o_vld  = sel_vld;
        o_sop  = sel_sop;
        o_eop  = sel_eop;
        o_rdy  = gnt_q & {NREQ{i_rdy}};
        if (sel_vld && i_rdy) begin
`ifdef ETH_TX_ARB_WDOG_EN
          wdog_d = '0;
`endif
          if (sel_eop) begin
            pkt_done = 1'b1;
            gnt_d    = '0;
            state_d  = IDLE;
          end
        end
`ifdef ETH_TX_ARB_WDOG_EN
        // Only source stalls age the watchdog; sink backpressure never does.
        else if (!sel_vld) begin
          if (wdog_q == WDOG_LAST) begin
            o_abort = 1'b1;
            state_d = TERM;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
`endif
      end
`ifdef ETH_TX_ARB_WDOG_EN
      TERM: begin
        o_vld = 1'b1;
        o_eop = 1'b1;
        if (i_rdy) begin
          pkt_done = 1'b1;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        o_rdy = gnt_q;
        if (sel_vld && sel_eop) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
`endif
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      starve_q  <= '0;
      pkt_cnt_q <= '0;
`ifdef ETH_TX_ARB_WDOG_EN
      wdog_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      starve_q <= starve_d;
      if (pkt_done)
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
`ifdef ETH_TX_ARB_WDOG_EN
      wdog_q   <= wdog_d;
`endif
    end
  end

  assign o_gnt     = gnt_q;
  assign o_busy    = (state_q != IDLE);
  assign o_pkt_cnt = pkt_cnt_q;

endmodule
